// File: rtl/m_ghost_engine_if.sv
// Ghost engine bus: game-logic handshake, player position, path ROM port and
// the renderer-facing ghost/collision outputs. The engine takes the slave side.
interface m_ghost_engine_if #(
    parameter int NUM_GHOSTS = 3,
    parameter int X_W        = 5,
    parameter int Y_W        = 4,
    parameter int ADDR_W     = 7
);
    logic                         start;
    logic                         busy;
    logic                         done;
    logic [X_W-1:0]               player_x;
    logic [Y_W-1:0]               player_y;
    logic [NUM_GHOSTS*ADDR_W-1:0] path_last;
    logic [2:0]                   rom_sel;
    logic [ADDR_W-1:0]            rom_addr;
    logic [X_W+Y_W-1:0]           rom_data;
    logic [NUM_GHOSTS*X_W-1:0]    ghost_x;
    logic [NUM_GHOSTS*Y_W-1:0]    ghost_y;
    logic [NUM_GHOSTS-1:0]        collision_mask;
    logic                         collision;

    modport slave (
        input  start, player_x, player_y, path_last, rom_data,
        output busy, done, rom_sel, rom_addr, ghost_x, ghost_y, collision_mask, collision
    );

    modport master (
        output start, player_x, player_y, path_last, rom_data,
        input  busy, done, rom_sel, rom_addr, ghost_x, ghost_y, collision_mask, collision
    );
endinterface

// File: rtl/m_ghost_engine.sv
// m_ghost_engine: once per game tick, advances every ghost one step along its
// path table, fetches the new coordinates ghost-by-ghost from the shared path
// ROM and flags ghosts that share the player's tile.
// Optional macro GHOST_SWEPT_COLLISION_EN: also flags a ghost and the player
// that swapped tiles during the tick (pass-through), using previous positions.
module m_ghost_engine #(
    parameter int NUM_GHOSTS = 3,
    parameter int X_W        = 5,
    parameter int Y_W        = 4,
    parameter int ADDR_W     = 7,
    parameter int ROM_LAT    = 1
) (
    input  logic            clock_i,
    input  logic            reset_i,
    m_ghost_engine_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(NUM_GHOSTS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(ROM_LAT - 1);

    logic [1:0]                        state_q, state_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [GW-1:0]                     gi_q, gi_d;
    logic [NUM_GHOSTS-1:0][ADDR_W-1:0] idx_q, idx_d;
    logic [NUM_GHOSTS-1:0][X_W-1:0]    gx_q;
    logic [NUM_GHOSTS-1:0][Y_W-1:0]    gy_q;
    logic [X_W-1:0]                    px_q;
    logic [Y_W-1:0]                    py_q;
    logic [2:0]                        sel_q;
    logic [ADDR_W-1:0]                 addr_q;
    logic [NUM_GHOSTS-1:0]             mask_q, mask_d;
    logic                              coll_q, done_q;
    logic [X_W-1:0]                    rom_x;
    logic [Y_W-1:0]                    rom_y;

    assign rom_x = bus.rom_data[X_W+Y_W-1 -: X_W];
    assign rom_y = bus.rom_data[Y_W-1:0];

`ifdef GHOST_SWEPT_COLLISION_EN
    logic [NUM_GHOSTS-1:0][X_W-1:0] gxp_q;
    logic [NUM_GHOSTS-1:0][Y_W-1:0] gyp_q;
    logic [X_W-1:0]                 pxp_q;
    logic [Y_W-1:0]                 pyp_q;
`endif

    // Per ghost: next path index (wraps at or beyond the table end) and hit test.
    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
        assign idx_d[g] = (idx_q[g] >= bus.path_last[g*ADDR_W +: ADDR_W]) ? '0 : idx_q[g] + 1'b1;
`ifdef GHOST_SWEPT_COLLISION_EN
        assign mask_d[g] = ((gx_q[g] == px_q) && (gy_q[g] == py_q)) ||
                           ((gxp_q[g] == px_q) && (gyp_q[g] == py_q) &&
                            (gx_q[g] == pxp_q) && (gy_q[g] == pyp_q));
`else
        assign mask_d[g] = (gx_q[g] == px_q) && (gy_q[g] == py_q);
`endif
    end

    // Sequencer: IDLE -> (FETCH x ROM_LAT -> LATCH) per ghost -> CHECK -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gi_d    = gi_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    gi_d    = '0;
                end
            end
            S_FETCH: begin
                if (cnt_q == C_LAST) state_d = S_LATCH;
                else                 cnt_d   = cnt_q + 1'b1;
            end
            S_LATCH: begin
                cnt_d = '0;
                if (gi_q == G_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    gi_d    = gi_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, path indices, ROM address, ghost positions and collision results.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gi_q    <= '0;
            idx_q   <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            coll_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gi_q    <= gi_d;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        idx_q  <= idx_d;
                        px_q   <= bus.player_x;
                        py_q   <= bus.player_y;
                        sel_q  <= '0;
                        addr_q <= idx_d[0];
                    end
                end
                S_LATCH: begin
                    gx_q[gi_q] <= rom_x;
                    gy_q[gi_q] <= rom_y;
                    // Point the ROM at the next ghost so its fetch window starts now.
                    sel_q      <= 3'(gi_d);
                    addr_q     <= idx_q[gi_d];
                end
                S_CHECK: begin
                    mask_q <= mask_d;
                    coll_q <= |mask_d;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef GHOST_SWEPT_COLLISION_EN
    // Previous-tick player snapshot and per-ghost previous position.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            gxp_q <= '0;
            gyp_q <= '0;
            pxp_q <= '0;
            pyp_q <= '0;
        end else begin
            if (state_q == S_IDLE && bus.start) begin
                pxp_q <= px_q;
                pyp_q <= py_q;
            end
            if (state_q == S_LATCH) begin
                gxp_q[gi_q] <= gx_q[gi_q];
                gyp_q[gi_q] <= gy_q[gi_q];
            end
        end
    end
`endif

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = done_q;
    assign bus.rom_sel        = sel_q;
    assign bus.rom_addr       = addr_q;
    assign bus.ghost_x        = gx_q;
    assign bus.ghost_y        = gy_q;
    assign bus.collision_mask = mask_q;
    assign bus.collision      = coll_q;
endmodule

// File: tb/tb_m_ghost_engine.sv
// Bench for m_ghost_engine: tile-level model of ghost walking and collision,
// a latency-ROM_LAT path ROM, a per-cycle compare process and literal checks.
module tb_m_ghost_engine;
    localparam int NG  = 3;
    localparam int XW  = 5;
    localparam int YW  = 4;
    localparam int AW  = 7;
    localparam int RL  = 1;
    localparam int LAT = NG * (RL + 1) + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    m_ghost_engine_if #(.NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW), .ADDR_W(AW)) bus();

    m_ghost_engine #(.NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW), .ADDR_W(AW), .ROM_LAT(RL)) dut (
        .clock_i(clock),
        .reset_i(reset),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- path ROM ----------------
    bit ov_en[NG];
    int ov_x[NG];
    int ov_y[NG];

    function automatic logic [XW+YW-1:0] rom_fn(input int g, input int a);
        if (g < NG && ov_en[g]) return {XW'(ov_x[g]), YW'(ov_y[g])};
        return {XW'(g), YW'(a)};
    endfunction

    logic [XW+YW-1:0] rom_pipe [RL];
    always @(posedge clock) begin
        rom_pipe[0] <= rom_fn(int'(bus.rom_sel), int'(bus.rom_addr));
        for (int j = 1; j < RL; j++) rom_pipe[j] <= rom_pipe[j-1];
    end
    assign bus.rom_data = rom_pipe[RL-1];

    // ---------------- model ----------------
    int last_m[NG];
    int idx_m[NG];
    int nx_x[NG], nx_y[NG], sh_x[NG], sh_y[NG];
    int ps_x, ps_y, pp_x, pp_y;
    logic [NG-1:0] nx_mask, sh_mask;
    bit pend;
    int e0, lat_seen, done_cnt, ck;
    logic [NG*XW-1:0] exg_x;
    logic [NG*YW-1:0] exg_y;

    function automatic void model_reset();
        for (int g = 0; g < NG; g++) begin
            idx_m[g] = 0; nx_x[g] = 0; nx_y[g] = 0; sh_x[g] = 0; sh_y[g] = 0;
        end
        ps_x = 0; ps_y = 0; pp_x = 0; pp_y = 0;
        nx_mask = '0; sh_mask = '0; pend = 1'b0;
    endfunction

    function automatic void model_accept(input int px, input int py);
        logic [XW+YW-1:0] d;
        pp_x = ps_x; pp_y = ps_y; ps_x = px; ps_y = py;
        for (int g = 0; g < NG; g++) begin
            idx_m[g] = (idx_m[g] >= last_m[g]) ? 0 : idx_m[g] + 1;
            d = rom_fn(g, idx_m[g]);
            nx_x[g] = int'(d[XW+YW-1:YW]);
            nx_y[g] = int'(d[YW-1:0]);
            nx_mask[g] = (nx_x[g] == ps_x) && (nx_y[g] == ps_y);
`ifdef GHOST_SWEPT_COLLISION_EN
            if (sh_x[g] == ps_x && sh_y[g] == ps_y && nx_x[g] == pp_x && nx_y[g] == pp_y)
                nx_mask[g] = 1'b1;
`endif
        end
    endfunction

    task automatic set_last(input int l0, input int l1, input int l2);
        last_m[0] = l0; last_m[1] = l1; last_m[2] = l2;
        for (int g = 0; g < NG; g++) bus.path_last[g*AW +: AW] = AW'(last_m[g]);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.done === 1'b1) done_cnt++;
            if (pend) begin
                ck = cyc - e0;
                if (ck < LAT) begin
                    chk("busy", bus.busy, 1);
                    chk("done", bus.done, 0);
                end else begin
                    chk("busy_at_done", bus.busy, 0);
                    chk("done_at_latency", bus.done, 1);
                    lat_seen = ck;
                    for (int g = 0; g < NG; g++) begin sh_x[g] = nx_x[g]; sh_y[g] = nx_y[g]; end
                    sh_mask = nx_mask;
                    pend = 1'b0;
                end
            end else begin
                chk("busy_idle", bus.busy, 0);
                chk("done_idle", bus.done, 0);
            end
            chk("collision_mask", bus.collision_mask, sh_mask);
            chk("collision", bus.collision, |sh_mask);
            if (!pend) begin
                for (int g = 0; g < NG; g++) begin
                    exg_x[g*XW +: XW] = XW'(sh_x[g]);
                    exg_y[g*YW +: YW] = YW'(sh_y[g]);
                end
                chk("ghost_x", bus.ghost_x, exg_x);
                chk("ghost_y", bus.ghost_y, exg_y);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int px, input int py, input int extra_at, input int rst_at);
        @(negedge clock);
        bus.player_x = XW'(px);
        bus.player_y = YW'(py);
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        e0 = cyc;
        model_accept(px, py);
        pend = 1'b1;
        if (extra_at > 0) begin
            repeat (extra_at - 1) @(posedge clock);
            #1 bus.start = 1'b1;
            @(posedge clock);
            #1 bus.start = 1'b0;
        end
        if (rst_at > 0) begin
            repeat (rst_at - (extra_at > 0 ? extra_at : 0)) @(posedge clock);
            #1 reset = 1'b1;
            model_reset();
            repeat (2) @(posedge clock);
            #1 reset = 1'b0;
        end else begin
            for (int w = 0; w < 200 && pend; w++) @(posedge clock);
            if (pend) begin
                chk("done_timeout", 1, 0);
                pend = 1'b0;
            end
            #1;
        end
    endtask

    int t2_g1[4] = '{1, 2, 0, 1};
    int d0;

    initial begin
        bus.start = 1'b0; bus.player_x = '0; bus.player_y = '0;
        for (int g = 0; g < NG; g++) ov_en[g] = 1'b0;
        done_cnt = 0; lat_seen = 0;
        set_last(5, 5, 5);
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_ghost_x", bus.ghost_x, 0);
        chk("reset_rom_addr", bus.rom_addr, 0);

        // T1: one tick, every ghost at index 1, done after 7 cycles
        tick(20, 15, 0, 0);
        chk("t1_latency", lat_seen, 7);
        for (int g = 0; g < NG; g++) begin
            chk("t1_gx", bus.ghost_x[g*XW +: XW], g);
            chk("t1_gy", bus.ghost_y[g*YW +: YW], 1);
        end

        // T2: ghost1 table ends at 2
        reset = 1'b1; model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        set_last(5, 2, 5);
        for (int t = 0; t < 4; t++) begin
            tick(20, 15, 0, 0);
            chk("t2_ghost1_idx", bus.ghost_y[1*YW +: YW], t2_g1[t]);
            chk("t2_ghost0_idx", bus.ghost_y[0*YW +: YW], t + 1);
        end
        // shortened table wraps; path_last 0 pins the ghost at index 0
        set_last(2, 2, 0);
        tick(20, 15, 0, 0);
        chk("wrap_ghost0", bus.ghost_y[0 +: YW], 0);
        chk("wrap_ghost2", bus.ghost_y[2*YW +: YW], 0);
        tick(20, 15, 0, 0);
        chk("wrap_ghost0_next", bus.ghost_y[0 +: YW], 1);
        chk("last0_ghost2", bus.ghost_y[2*YW +: YW], 0);

        // T3: ghost2 lands on the player, result held until the next done
        ov_en[2] = 1'b1; ov_x[2] = 3; ov_y[2] = 2;
        tick(3, 2, 0, 0);
        chk("t3_mask", bus.collision_mask, 3'b100);
        chk("t3_collision", bus.collision, 1);
        repeat (5) @(posedge clock);
        #1 chk("t3_mask_held", bus.collision_mask, 3'b100);
        ov_en[2] = 1'b0;
        tick(20, 15, 0, 0);
        chk("t3_mask_cleared", bus.collision_mask, 0);

        // T4: start while busy is dropped
        d0 = done_cnt;
        tick(20, 15, 3, 0);
        repeat (LAT + 2) @(posedge clock);
        #1;
        chk("t4_single_done", done_cnt - d0, 1);
        chk("t4_latency", lat_seen, 7);

        // T5: reset mid-operation aborts with no done
        set_last(5, 5, 5);
        d0 = done_cnt;
        tick(20, 15, 0, 4);
        repeat (LAT + 3) @(posedge clock);
        #1;
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_ghost_y", bus.ghost_y, 0);
        tick(20, 15, 0, 0);
        for (int g = 0; g < NG; g++) chk("t5_restart_idx", bus.ghost_y[g*YW +: YW], 1);

        // T6: ghost0 and player swap tiles
        ov_en[0] = 1'b1; ov_x[0] = 5; ov_y[0] = 1;
        tick(4, 1, 0, 0);
        chk("t6_first_mask", bus.collision_mask, 0);
        ov_x[0] = 4; ov_y[0] = 1;
        tick(5, 1, 0, 0);
`ifdef GHOST_SWEPT_COLLISION_EN
        chk("t6_swap_mask", bus.collision_mask, 3'b001);
`else
        chk("t6_swap_mask", bus.collision_mask, 3'b000);
`endif
        repeat (3) @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
